// File: rtl/csa_tree_adder_if.sv
// rtl/csa_tree_adder_if.sv - operand/sum valid-ready bundle for csa_tree_adder
interface csa_tree_adder_if #(
   parameter int NUM_OPS = 6,
   parameter int WIDTH   = 8,
   parameter int OUT_W   = WIDTH + $clog2(NUM_OPS)
);
   logic                     in_valid;
   logic                     in_ready;
   logic [NUM_OPS*WIDTH-1:0] in_ops;
   logic                     out_valid;
   logic                     out_ready;
   logic [OUT_W-1:0]         out_sum;

   // Environment side: supplies operands and consumes sums
   modport master (
      output in_valid,
      output in_ops,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_sum
   );

   // Adder side
   modport slave (
      input  in_valid,
      input  in_ops,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_sum
   );
endinterface

// File: rtl/csa_tree_adder.sv
// rtl/csa_tree_adder.sv - pipelined Wallace-tree multi-operand adder with valid/ready stall
module csa_tree_adder #(
   parameter int NUM_OPS   = 6,
   parameter int WIDTH     = 8,
   parameter     SIGNED    = "FALSE",
   parameter int REG_EVERY = 1,
   parameter int OUT_W     = WIDTH + $clog2(NUM_OPS)
) (
   input  logic            clk,
   input  logic            rst_n,
   csa_tree_adder_if.slave bus_io
);

   // Row count after one layer of 3:2 counters; leftovers pass through.
   function automatic int rows_after(input int n);
      return 2 * (n / 3) + (n % 3);
   endfunction

   // Number of 3:2 layers needed to bring NUM_OPS rows down to two.
   function automatic int count_layers(input int n);
      int m;
      int c;
      m = n;
      c = 0;
      while (m > 2) begin
         m = rows_after(m);
         c = c + 1;
      end
      return c;
   endfunction

   localparam int LAYERS    = count_layers(NUM_OPS);
   localparam int NSTG      = (REG_EVERY > 0) ? (LAYERS / REG_EVERY) : 0;
   localparam int NSTG_A    = (NSTG > 0) ? NSTG : 1;
   localparam int RE_DIV    = (REG_EVERY > 0) ? REG_EVERY : 1;
   localparam bit IS_SIGNED = (SIGNED == "TRUE");
   localparam int MAXR      = NUM_OPS;
   localparam int NGRP      = MAXR / 3;
   localparam int EXT_W     = OUT_W - WIDTH;

   logic                 en;
   logic [OUT_W-1:0]     cur_rows [MAXR];
   logic [OUT_W-1:0]     nxt_rows [MAXR];
   logic [OUT_W-1:0]     stage_d  [NSTG_A][MAXR];
   logic [OUT_W-1:0]     stage_q  [NSTG_A][MAXR];
   logic [NSTG_A-1:0]    vld_d;
   logic [NSTG_A-1:0]    vld_q;
   logic                 last_vld;
   logic [OUT_W-1:0]     out_sum_d;
   logic [OUT_W-1:0]     out_sum_q;
   logic                 out_valid_q;

   // Whole pipeline moves together; only a stuck output can stall it.
   assign en               = !out_valid_q || bus_io.out_ready;
   assign bus_io.in_ready  = en;
   assign bus_io.out_valid = out_valid_q;
   assign bus_io.out_sum   = out_sum_q;

   // Extend operands, run the 3:2 layers (tapping stage registers), then the final CPA
   always_comb begin
      int n;
      int grp;
      int left;
      int s;
      logic [OUT_W-1:0] a;
      logic [OUT_W-1:0] b;
      logic [OUT_W-1:0] c;

      n    = NUM_OPS;
      grp  = 0;
      left = 0;
      s    = 0;
      a    = '0;
      b    = '0;
      c    = '0;

      for (int i = 0; i < MAXR; i++) begin
         if (IS_SIGNED) begin
            cur_rows[i] = {{EXT_W{bus_io.in_ops[i*WIDTH + WIDTH - 1]}},
                           bus_io.in_ops[i*WIDTH +: WIDTH]};
         end else begin
            cur_rows[i] = {{EXT_W{1'b0}}, bus_io.in_ops[i*WIDTH +: WIDTH]};
         end
         nxt_rows[i] = '0;
      end

      for (int t = 0; t < NSTG_A; t++) begin
         for (int r = 0; r < MAXR; r++) begin
            stage_d[t][r] = stage_q[t][r];
         end
      end

      for (int k = 1; k <= LAYERS; k++) begin
         grp  = n / 3;
         left = n % 3;
         for (int r = 0; r < MAXR; r++) begin
            nxt_rows[r] = '0;
         end
         // Each full group of three rows becomes a sum row and a shifted carry row
         for (int g = 0; g < NGRP; g++) begin
            if (g < grp) begin
               a = cur_rows[3*g];
               b = cur_rows[3*g + 1];
               c = cur_rows[3*g + 2];
               nxt_rows[2*g]     = a ^ b ^ c;
               nxt_rows[2*g + 1] = ((a & b) | (a & c) | (b & c)) << 1;
            end
         end
         for (int r = 0; r < 2; r++) begin
            if (r < left) begin
               nxt_rows[2*grp + r] = cur_rows[3*grp + r];
            end
         end
         n = rows_after(n);

         // Registered boundary: capture this layer, feed the next layer from the register
         if ((REG_EVERY > 0) && ((k % RE_DIV) == 0)) begin
            s = (k / RE_DIV) - 1;
            for (int r = 0; r < MAXR; r++) begin
               stage_d[s][r] = nxt_rows[r];
               cur_rows[r]   = stage_q[s][r];
            end
         end else begin
            for (int r = 0; r < MAXR; r++) begin
               cur_rows[r] = nxt_rows[r];
            end
         end
      end

      out_sum_d = cur_rows[0] + cur_rows[1];
   end

   // Stage valid shift chain; the output register sees the last stage (or the input when unstaged)
   always_comb begin
      vld_d[0] = bus_io.in_valid;
      for (int i = 1; i < NSTG_A; i++) begin
         vld_d[i] = vld_q[i-1];
      end
      last_vld = (NSTG > 0) ? vld_q[NSTG_A-1] : bus_io.in_valid;
   end

   // Control and output registers, cleared by reset so no stale bundle survives
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q       <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
      end else if (en) begin
         vld_q       <= vld_d;
         out_valid_q <= last_vld;
         out_sum_q   <= out_sum_d;
      end
   end

   // Stage data registers advance with the pipeline; their contents are qualified by vld_q
   always_ff @(posedge clk) begin
      if (en) begin
         for (int t = 0; t < NSTG_A; t++) begin
            for (int r = 0; r < MAXR; r++) begin
               stage_q[t][r] <= stage_d[t][r];
            end
         end
      end
   end

endmodule

// File: tb/tb_csa_tree_adder.sv
// tb/tb_csa_tree_adder.sv - directed self-checking bench for csa_tree_adder
module tb_csa_tree_adder;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   csa_tree_adder_if #(.NUM_OPS(6), .WIDTH(8)) if_a  ();
   csa_tree_adder_if #(.NUM_OPS(6), .WIDTH(8)) if_s  ();
   csa_tree_adder_if #(.NUM_OPS(6), .WIDTH(8)) if_r2 ();
   csa_tree_adder_if #(.NUM_OPS(6), .WIDTH(8)) if_r0 ();
   csa_tree_adder_if #(.NUM_OPS(2), .WIDTH(8)) if_n2 ();
   csa_tree_adder_if #(.NUM_OPS(3), .WIDTH(8)) if_n3a();
   csa_tree_adder_if #(.NUM_OPS(3), .WIDTH(8)) if_n3b();

   csa_tree_adder #(.NUM_OPS(6), .WIDTH(8), .SIGNED("FALSE"), .REG_EVERY(1))
      u_a   (.clk(clk), .rst_n(rst_n), .bus_io(if_a));
   csa_tree_adder #(.NUM_OPS(6), .WIDTH(8), .SIGNED("TRUE"),  .REG_EVERY(1))
      u_s   (.clk(clk), .rst_n(rst_n), .bus_io(if_s));
   csa_tree_adder #(.NUM_OPS(6), .WIDTH(8), .SIGNED("FALSE"), .REG_EVERY(2))
      u_r2  (.clk(clk), .rst_n(rst_n), .bus_io(if_r2));
   csa_tree_adder #(.NUM_OPS(6), .WIDTH(8), .SIGNED("FALSE"), .REG_EVERY(0))
      u_r0  (.clk(clk), .rst_n(rst_n), .bus_io(if_r0));
   csa_tree_adder #(.NUM_OPS(2), .WIDTH(8), .SIGNED("FALSE"), .REG_EVERY(1))
      u_n2  (.clk(clk), .rst_n(rst_n), .bus_io(if_n2));
   csa_tree_adder #(.NUM_OPS(3), .WIDTH(8), .SIGNED("FALSE"), .REG_EVERY(0))
      u_n3a (.clk(clk), .rst_n(rst_n), .bus_io(if_n3a));
   csa_tree_adder #(.NUM_OPS(3), .WIDTH(8), .SIGNED("FALSE"), .REG_EVERY(1))
      u_n3b (.clk(clk), .rst_n(rst_n), .bus_io(if_n3b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Valid must rise exactly at cycle lat; the sum is checked on that cycle.
   task automatic lat_chk(input string tag, input logic v, input logic [31:0] sum,
                          input int cyc, input int lat, input logic [31:0] exp);
      chk($sformatf("%s_valid_c%0d", tag, cyc), v, (cyc == lat));
      if (cyc == lat) chk($sformatf("%s_sum", tag), sum, exp);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      if_a.in_valid = 0;   if_a.in_ops = '0;   if_a.out_ready = 1;
      if_s.in_valid = 0;   if_s.in_ops = '0;   if_s.out_ready = 1;
      if_r2.in_valid = 0;  if_r2.in_ops = '0;  if_r2.out_ready = 1;
      if_r0.in_valid = 0;  if_r0.in_ops = '0;  if_r0.out_ready = 1;
      if_n2.in_valid = 0;  if_n2.in_ops = '0;  if_n2.out_ready = 1;
      if_n3a.in_valid = 0; if_n3a.in_ops = '0; if_n3a.out_ready = 1;
      if_n3b.in_valid = 0; if_n3b.in_ops = '0; if_n3b.out_ready = 1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_a_valid",   if_a.out_valid, 0);   chk("rst_a_sum",   if_a.out_sum, 0);
      chk("rst_a_ready",   if_a.in_ready, 1);
      chk("rst_s_valid",   if_s.out_valid, 0);   chk("rst_s_sum",   if_s.out_sum, 0);
      chk("rst_r2_valid",  if_r2.out_valid, 0);  chk("rst_r2_sum",  if_r2.out_sum, 0);
      chk("rst_r0_valid",  if_r0.out_valid, 0);  chk("rst_r0_sum",  if_r0.out_sum, 0);
      chk("rst_n2_valid",  if_n2.out_valid, 0);  chk("rst_n2_sum",  if_n2.out_sum, 0);
      chk("rst_n3a_valid", if_n3a.out_valid, 0); chk("rst_n3a_sum", if_n3a.out_sum, 0);
      chk("rst_n3b_valid", if_n3b.out_valid, 0); chk("rst_n3b_sum", if_n3b.out_sum, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Single bundle into every configuration; check exact latency and sum
      @(posedge clk); #1;
      if_a.in_valid = 1;   if_a.in_ops   = {6{8'hFF}};
      if_s.in_valid = 1;   if_s.in_ops   = {6{8'h80}};
      if_r2.in_valid = 1;  if_r2.in_ops  = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      if_r0.in_valid = 1;  if_r0.in_ops  = {6{8'hFF}};
      if_n2.in_valid = 1;  if_n2.in_ops  = {8'h05, 8'h03};
      if_n3a.in_valid = 1; if_n3a.in_ops = {8'h04, 8'h02, 8'h01};
      if_n3b.in_valid = 1; if_n3b.in_ops = {8'h04, 8'h02, 8'h01};
      @(negedge clk);
      chk("lat_a_in_ready", if_a.in_ready, 1);
      for (int cyc = 1; cyc <= 4; cyc++) begin
         @(posedge clk); #1;
         if_a.in_valid = 0; if_s.in_valid = 0; if_r2.in_valid = 0; if_r0.in_valid = 0;
         if_n2.in_valid = 0; if_n3a.in_valid = 0; if_n3b.in_valid = 0;
         @(negedge clk);
         chk($sformatf("lat_a_in_ready_c%0d", cyc), if_a.in_ready, 1);
         lat_chk("u6_ff",    if_a.out_valid,   if_a.out_sum,   cyc, 4, 32'h5FA);
         lat_chk("s6_80",    if_s.out_valid,   if_s.out_sum,   cyc, 4, 32'h500);
         lat_chk("r2_seq",   if_r2.out_valid,  if_r2.out_sum,  cyc, 2, 32'h015);
         lat_chk("r0_ff",    if_r0.out_valid,  if_r0.out_sum,  cyc, 1, 32'h5FA);
         lat_chk("n2_add",   if_n2.out_valid,  if_n2.out_sum,  cyc, 1, 32'h008);
         lat_chk("n3_re0",   if_n3a.out_valid, if_n3a.out_sum, cyc, 1, 32'h007);
         lat_chk("n3_re1",   if_n3b.out_valid, if_n3b.out_sum, cyc, 2, 32'h007);
      end

      // Signed mixed-sign operands: 0x7F + 0x01 + 0xFF(-1) = 127
      @(posedge clk); #1;
      if_s.in_valid = 1; if_s.in_ops = {8'h00, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h7F};
      for (int cyc = 1; cyc <= 4; cyc++) begin
         @(posedge clk); #1;
         if_s.in_valid = 0;
         @(negedge clk);
         lat_chk("s6_mix", if_s.out_valid, if_s.out_sum, cyc, 4, 32'h07F);
      end

      // Back-to-back: bundle j (all operands j+1) presented in cycle j, emerges in cycle j+4
      for (int cyc = 0; cyc < 14; cyc++) begin
         @(posedge clk); #1;
         if_a.in_valid = (cyc < 10);
         if_a.in_ops   = {6{8'(cyc + 1)}};
         @(negedge clk);
         chk($sformatf("b2b_in_ready_c%0d", cyc), if_a.in_ready, 1);
         chk($sformatf("b2b_valid_c%0d", cyc), if_a.out_valid, (cyc >= 4));
         if (cyc >= 4) chk($sformatf("b2b_sum_c%0d", cyc), if_a.out_sum, 6 * (cyc - 3));
      end

      // Backpressure: three bundles in flight, output stalled for five cycles
      for (int cyc = 0; cyc < 13; cyc++) begin
         @(posedge clk); #1;
         if (cyc < 3) begin
            if_a.in_valid = 1; if_a.in_ops = {6{8'(16 * (cyc + 1))}}; if_a.out_ready = 1;
         end else if (cyc < 4) begin
            if_a.in_valid = 0; if_a.out_ready = 1;
         end else if (cyc < 9) begin
            if_a.in_valid = 1; if_a.in_ops = {6{8'h77}}; if_a.out_ready = 0;
         end else begin
            if_a.in_valid = 0; if_a.out_ready = 1;
         end
         @(negedge clk);
         if (cyc < 4) begin
            chk($sformatf("bp_valid_c%0d", cyc), if_a.out_valid, 0);
            chk($sformatf("bp_in_ready_c%0d", cyc), if_a.in_ready, 1);
         end else if (cyc < 9) begin
            chk($sformatf("bp_hold_valid_c%0d", cyc), if_a.out_valid, 1);
            chk($sformatf("bp_hold_sum_c%0d", cyc), if_a.out_sum, 32'h060);
            chk($sformatf("bp_in_ready_c%0d", cyc), if_a.in_ready, 0);
         end else if (cyc < 12) begin
            chk($sformatf("bp_drain_valid_c%0d", cyc), if_a.out_valid, 1);
            chk($sformatf("bp_drain_sum_c%0d", cyc), if_a.out_sum, 32'h060 * (cyc - 8));
         end else begin
            chk("bp_empty_valid", if_a.out_valid, 0);
         end
      end

      // Reset mid-flight with a result at the output and two behind it
      for (int cyc = 0; cyc < 15; cyc++) begin
         @(posedge clk); #1;
         rst_n = (cyc != 4);
         if (cyc < 3) begin
            if_a.in_valid = 1; if_a.in_ops = {6{8'(cyc + 1)}};
         end else if (cyc == 10) begin
            if_a.in_valid = 1; if_a.in_ops = {6{8'h05}};
         end else begin
            if_a.in_valid = 0;
         end
         @(negedge clk);
         if (cyc == 4) begin
            chk("mrst_pre_valid", if_a.out_valid, 1);
            chk("mrst_pre_sum", if_a.out_sum, 32'h006);
         end else if (cyc == 5) begin
            chk("mrst_post_valid", if_a.out_valid, 0);
            chk("mrst_post_sum", if_a.out_sum, 0);
         end else if (cyc > 5) begin
            chk($sformatf("mrst_valid_c%0d", cyc), if_a.out_valid, (cyc == 14));
            if (cyc == 14) chk("mrst_first_sum", if_a.out_sum, 32'h01E);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
